// File: rtl/findmax_pkg.sv
// Shared types and constants for the FindMax engine scheduler.
package findmax_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LAUNCH  = 3'd1,
    WAIT    = 3'd2,
    RESP    = 3'd3,
    RECOVER = 3'd4
  } state_e;

  // Engine pipeline depth, DataValid cycle to done cycle.
  localparam int unsigned ENG_LATENCY = 7;

  localparam int unsigned DEF_N_EXP = 36;
  localparam int unsigned DEF_EXP_W = 5;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first valid requester above last_grant, wrapping to 0.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req_valid,
  input  logic [ID_W-1:0]    i_last_grant,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [ID_W-1:0]    o_grant_id,
  output logic               o_any
);

  logic [NUM_REQ-1:0] w_hi_mask;
  logic [NUM_REQ-1:0] w_hi_req;
  logic [NUM_REQ-1:0] w_pick_vec;

  always_comb begin
    w_hi_mask = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      w_hi_mask[j] = (j > int'(i_last_grant));
    end
  end

  assign w_hi_req   = i_req_valid & w_hi_mask;
  // Requesters above the last winner go first; otherwise wrap around to the lowest index.
  assign w_pick_vec = (|w_hi_req) ? w_hi_req : i_req_valid;

  always_comb begin
    o_grant_id = '0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (w_pick_vec[j]) o_grant_id = ID_W'(j);
    end
  end

  assign o_any   = |i_req_valid;
  assign o_grant = o_any ? (NUM_REQ'(1) << o_grant_id) : '0;

endmodule

// File: rtl/findmax_arbiter.sv
// Shares one FindMax exponent-max engine among NUM_REQ requesters, with a watchdog
// that resets a hung engine and returns an error response.
module findmax_arbiter
  import findmax_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned N_EXP   = DEF_N_EXP,
  parameter int unsigned EXP_W   = DEF_EXP_W,
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           RST,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*N_EXP*EXP_W-1:0] req_exp,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [ID_W-1:0]                rsp_id,
  output logic [EXP_W-1:0]               rsp_max,
  output logic                           rsp_err,
  output logic                           eng_data_valid,
  output logic                           eng_rstn,
  output logic [N_EXP*EXP_W-1:0]         eng_exp,
  input  logic                           eng_done,
  input  logic [EXP_W-1:0]               eng_max
);

  localparam int unsigned BLK_W  = N_EXP * EXP_W;
  localparam int unsigned WDOG_W = $clog2(TIMEOUT);

  if (TIMEOUT <= ENG_LATENCY + 1) begin : g_timeout_chk
    $error("TIMEOUT must exceed the engine latency");
  end

  state_e             r_state, w_state_nxt;
  logic [ID_W-1:0]    r_last_grant;
  logic [ID_W-1:0]    r_owner;
  logic [BLK_W-1:0]   r_hold;
  logic [WDOG_W-1:0]  r_wdog;
  logic               r_rsp_valid;
  logic [EXP_W-1:0]   r_rsp_max;
  logic               r_rsp_err;
  logic               r_eng_dv;
  logic               r_eng_rstn;

  logic [NUM_REQ-1:0] w_grant;
  logic [ID_W-1:0]    w_gnt_id;
  logic               w_any;
  logic [BLK_W-1:0]   w_slice;
  logic               w_wdog_exp;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .i_req_valid  (req_valid),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant),
    .o_grant_id   (w_gnt_id),
    .o_any        (w_any)
  );

  always_comb begin
    w_slice = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (w_gnt_id == ID_W'(r)) w_slice = req_exp[r*BLK_W +: BLK_W];
    end
  end

  assign w_wdog_exp = (r_wdog == WDOG_W'(TIMEOUT - 1));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_any) w_state_nxt = LAUNCH;
      LAUNCH:  w_state_nxt = WAIT;
      // A done arriving on the timeout cycle still counts as a normal completion.
      WAIT: begin
        if (eng_done)        w_state_nxt = RESP;
        else if (w_wdog_exp) w_state_nxt = RECOVER;
      end
      RECOVER: w_state_nxt = RESP;
      RESP:    if (rsp_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      r_state      <= IDLE;
      r_last_grant <= ID_W'(NUM_REQ - 1);
      r_owner      <= '0;
      r_hold       <= '0;
      r_wdog       <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_max    <= '0;
      r_rsp_err    <= 1'b0;
      r_eng_dv     <= 1'b0;
      r_eng_rstn   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_eng_dv    <= (w_state_nxt == LAUNCH);
      r_eng_rstn  <= (w_state_nxt != RECOVER);
      r_rsp_valid <= (w_state_nxt == RESP);
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_hold       <= w_slice;
            r_owner      <= w_gnt_id;
            r_last_grant <= w_gnt_id;
          end
        end
        LAUNCH: r_wdog <= '0;
        WAIT: begin
          if (eng_done) begin
            r_rsp_max <= eng_max;
            r_rsp_err <= 1'b0;
          end else begin
            r_wdog <= r_wdog + WDOG_W'(1);
          end
        end
        RECOVER: begin
          r_rsp_max <= '0;
          r_rsp_err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Grants are suppressed while reset is held so no requester sees a phantom accept.
  assign req_ready      = (r_state == IDLE && !RST) ? w_grant : '0;
  assign rsp_valid      = r_rsp_valid;
  assign rsp_id         = r_owner;
  assign rsp_max        = r_rsp_max;
  assign rsp_err        = r_rsp_err;
  assign eng_data_valid = r_eng_dv;
  assign eng_rstn       = r_eng_rstn;
  assign eng_exp        = r_hold;

endmodule

// File: tb/tb_findmax_arbiter.sv
// Directed bench for findmax_arbiter with a behavioural engine of configurable done delay.
module tb_findmax_arbiter;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned N_EXP   = 36;
  localparam int unsigned EXP_W   = 5;
  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned ID_W    = 2;
  localparam int unsigned BLK_W   = N_EXP * EXP_W;

  logic                       clk = 1'b0;
  logic                       RST;
  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ*BLK_W-1:0]   req_exp;
  logic [NUM_REQ-1:0]         req_ready;
  logic                       rsp_valid;
  logic                       rsp_ready;
  logic [ID_W-1:0]            rsp_id;
  logic [EXP_W-1:0]           rsp_max;
  logic                       rsp_err;
  logic                       eng_data_valid;
  logic                       eng_rstn;
  logic [BLK_W-1:0]           eng_exp;
  logic                       eng_done;
  logic [EXP_W-1:0]           eng_max;

  int         errors = 0;
  int         checks = 0;
  int         cycle_cnt = 0;
  int         eng_delay = 7;
  logic [4:0] eng_max_val = '0;
  bit         stale_req = 1'b0;

  findmax_arbiter #(
    .NUM_REQ (NUM_REQ),
    .N_EXP   (N_EXP),
    .EXP_W   (EXP_W),
    .TIMEOUT (TIMEOUT),
    .ID_W    (ID_W)
  ) dut (
    .clk            (clk),
    .RST            (RST),
    .req_valid      (req_valid),
    .req_exp        (req_exp),
    .req_ready      (req_ready),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_id         (rsp_id),
    .rsp_max        (rsp_max),
    .rsp_err        (rsp_err),
    .eng_data_valid (eng_data_valid),
    .eng_rstn       (eng_rstn),
    .eng_exp        (eng_exp),
    .eng_done       (eng_done),
    .eng_max        (eng_max)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  function automatic logic [BLK_W-1:0] blk(input int r);
    logic [BLK_W-1:0] v;
    v = '0;
    for (int k = 0; k < N_EXP; k++) begin
      v[k*EXP_W +: EXP_W] = (r == 2) ? EXP_W'(k % 31) : EXP_W'((k * 3 + r * 5 + 1) % 32);
    end
    return v;
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [199:0] obs, input logic [199:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (req_ready != '0) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic wait_rsp(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (rsp_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  // Engine: done pulse eng_delay cycles after the DataValid cycle; 0 means never.
  initial begin : engine
    int cnt;
    cnt      = 0;
    eng_done = 1'b0;
    eng_max  = '0;
    forever begin
      @(posedge clk);
      #1;
      eng_done = 1'b0;
      if (!eng_rstn) begin
        cnt = 0;
      end else begin
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            eng_done = 1'b1;
            eng_max  = eng_max_val;
          end
        end
        if (eng_data_valid && eng_delay > 0) cnt = eng_delay;
      end
      if (stale_req) begin
        eng_done  = 1'b1;
        stale_req = 1'b0;
      end
    end
  end

  initial begin : guard
    #100000;
    $display("FAIL global_timeout: observed=hang expected=finish");
    $fatal(1);
  end

  initial begin : stim
    bit         ok;
    int         n, low, low_at, first, last_acc, exp_id;
    logic [3:0] exp_gnt;

    RST       = 1'b1;
    req_valid = '0;
    req_exp   = {blk(3), blk(2), blk(1), blk(0)};
    rsp_ready = 1'b0;
    step();
    step();
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_max", rsp_max, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_eng_dv", eng_data_valid, 0);
    chk("rst_eng_exp", eng_exp, 0);
    chk("rst_eng_rstn", eng_rstn, 0);
    chk("rst_req_ready", req_ready, 0);
    RST = 1'b0;
    step();
    chk("rst_rel_eng_rstn", eng_rstn, 1);

    // Single job from requester 2
    eng_max_val = 5'd30;
    req_valid   = 4'b0100;
    #1;
    chk("t1_ready", req_ready, 4'b0100);
    step();
    chk("t1_dv", eng_data_valid, 1);
    chk("t1_exp", eng_exp, blk(2));
    chk("t1_ready_low", req_ready, 0);
    req_valid = '0;
    n = 0;
    for (int i = 0; i < 7; i++) begin
      step();
      if (rsp_valid !== 1'b0 || eng_data_valid !== 1'b0) n++;
    end
    chk("t1_quiet_wait", n, 0);
    step();
    chk("t1_rsp_valid", rsp_valid, 1);
    chk("t1_rsp_id", rsp_id, 2);
    chk("t1_rsp_max", rsp_max, 30);
    chk("t1_rsp_err", rsp_err, 0);
    rsp_ready = 1'b1;
    step();
    chk("t1_rsp_drop", rsp_valid, 0);
    rsp_ready = 1'b0;

    // Round-robin from a fresh reset
    RST = 1'b1;
    step();
    RST = 1'b0;
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    last_acc  = 0;
    #1;
    for (int j = 0; j < 5; j++) begin
      wait_ready(ok);
      chk("t2_ready_seen", ok, 1);
      exp_id  = j % 4;
      exp_gnt = 4'b0001 << exp_id;
      chk("t2_grant", req_ready, exp_gnt);
      if (j > 0) chk("t2_period", cycle_cnt - last_acc, 10);
      last_acc    = cycle_cnt;
      eng_max_val = 5'(20 + j);
      step();
      chk("t2_exp", eng_exp, blk(exp_id));
      if (j == 4) req_valid = '0;
      wait_rsp(ok);
      chk("t2_rsp_seen", ok, 1);
      chk("t2_rsp_id", rsp_id, exp_id);
      chk("t2_rsp_max", rsp_max, 20 + j);
      step();
    end

    // Backpressure; last grant is 0 so requester 1 beats requester 3
    rsp_ready   = 1'b0;
    eng_max_val = 5'd11;
    req_valid   = 4'b1010;
    #1;
    chk("t3_grant", req_ready, 4'b0010);
    step();
    chk("t3_exp", eng_exp, blk(1));
    req_valid = 4'b1000;
    wait_rsp(ok);
    chk("t3_rsp_seen", ok, 1);
    chk("t3_rsp_id", rsp_id, 1);
    chk("t3_rsp_max", rsp_max, 11);
    n = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_max !== 5'd11 || rsp_err !== 1'b0 ||
          eng_exp !== blk(1) || req_ready !== 4'b0000) n++;
    end
    chk("t3_stable", n, 0);
    eng_delay = 0;
    rsp_ready = 1'b1;
    #1;
    chk("t3_no_early_grant", req_ready, 0);
    step();
    chk("t3_rsp_drop", rsp_valid, 0);
    chk("t3_next_grant", req_ready, 4'b1000);
    rsp_ready = 1'b0;

    // Watchdog: engine never answers requester 3
    low = 0; low_at = 0; n = 0;
    for (int i = 1; i <= 19; i++) begin
      step();
      if (i == 1) req_valid = '0;
      if (!eng_rstn) begin
        low++;
        low_at = i;
      end
      if (i < 19 && rsp_valid) n++;
    end
    chk("t4_rstn_low_cnt", low, 1);
    chk("t4_rstn_low_at", low_at, 18);
    chk("t4_no_early_rsp", n, 0);
    chk("t4_rsp_valid", rsp_valid, 1);
    chk("t4_rsp_err", rsp_err, 1);
    chk("t4_rsp_max", rsp_max, 0);
    chk("t4_rsp_id", rsp_id, 3);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("t4_rsp_drop", rsp_valid, 0);

    // Normal job after abort
    eng_delay   = 7;
    eng_max_val = 5'd17;
    req_valid   = 4'b0001;
    #1;
    chk("t5_grant", req_ready, 4'b0001);
    step();
    req_valid = '0;
    wait_rsp(ok);
    chk("t5_rsp_seen", ok, 1);
    chk("t5_rsp_id", rsp_id, 0);
    chk("t5_rsp_max", rsp_max, 17);
    chk("t5_rsp_err", rsp_err, 0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;

    // Done on the timeout cycle wins
    eng_delay   = 16;
    eng_max_val = 5'd9;
    req_valid   = 4'b0100;
    #1;
    chk("t6_grant", req_ready, 4'b0100);
    low = 0; first = 0;
    for (int i = 1; i <= 18; i++) begin
      step();
      if (i == 1) req_valid = '0;
      if (!eng_rstn) low++;
      if (rsp_valid && first == 0) first = i;
    end
    chk("t6_rsp_at", first, 18);
    chk("t6_no_rstn", low, 0);
    chk("t6_rsp_err", rsp_err, 0);
    chk("t6_rsp_max", rsp_max, 9);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    eng_delay = 7;

    // Stale done while idle
    stale_req = 1'b1;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (rsp_valid !== 1'b0 || req_ready !== 4'b0000 || eng_data_valid !== 1'b0) n++;
    end
    chk("t7_stale_ignored", n, 0);
    chk("t7_stale_fired", stale_req, 0);

    // Async reset during WAIT
    eng_max_val = 5'd5;
    req_valid   = 4'b0100;
    #1;
    chk("t8_grant", req_ready, 4'b0100);
    step();
    req_valid = '0;
    step();
    step();
    step();
    req_valid = 4'b1001;
    RST = 1'b1;
    #1;
    chk("t8_rst_rsp_valid", rsp_valid, 0);
    chk("t8_rst_eng_rstn", eng_rstn, 0);
    chk("t8_rst_req_ready", req_ready, 0);
    step();
    step();
    RST = 1'b0;
    #1;
    chk("t8_prio0", req_ready, 4'b0001);
    chk("t8_hold_clr", eng_exp, 0);
    step();
    req_valid = '0;
    wait_rsp(ok);
    chk("t8_rsp_seen", ok, 1);
    chk("t8_rsp_id", rsp_id, 0);
    chk("t8_rsp_max", rsp_max, 5);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/findmax_arbiter.md
Name: findmax_arbiter

Overview:
- Round-robin scheduler that shares one FindMax_tree exponent-max engine among NUM_REQ CIM requesters (e.g. macro row-groups).
- Per job: accepts one 36-exponent block from the winning requester, holds it stable into the engine, and pulses the engine start.
- Waits for the engine's done pulse, then returns the max exponent tagged with requester ID.
- A watchdog resets the engine and returns an error response if done never arrives.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- N_EXP, 36, exponents per block (must match engine)
- EXP_W, 5, exponent width
- TIMEOUT, 16, max WAIT cycles before abort (must be > 8)
- ID_W, $clog2(NUM_REQ), requester ID width

Ports:
- clk  in  1  clock
- RST  in  1  reset; asynchronous, active-high
- req_valid  in  NUM_REQ  per-requester job request
- req_exp  in  NUM_REQ*N_EXP*EXP_W  flattened blocks; requester r occupies bits [r*N_EXP*EXP_W +: N_EXP*EXP_W], exponent k at [k*EXP_W +: EXP_W] within it
- req_ready  out  NUM_REQ  one-hot accept strobe
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed
- rsp_id  out  ID_W  requester that owns the response
- rsp_max  out  EXP_W  max exponent
- rsp_err  out  1  watchdog abort flag
- eng_data_valid  out  1  engine DataValid
- eng_rstn  out  1  engine active-low reset
- eng_exp  out  N_EXP*EXP_W  held block to engine
- eng_done  in  1  engine done pulse
- eng_max  in  EXP_W  engine final_max

Behaviour:
- Reset (async, RST=1):
  - state=IDLE; last_grant=NUM_REQ-1.
  - rsp_valid=0, rsp_id=0, rsp_max=0, rsp_err=0.
  - eng_data_valid=0, eng_exp hold register=0, wdog=0.
  - eng_rstn=0 while RST high.
- States IDLE, LAUNCH, WAIT, RESP, RECOVER.
- IDLE:
  - If any req_valid, pick the first set bit searching upward from last_grant+1 with wrap.
  - req_ready[g]=1 combinationally in the same cycle; all other bits 0.
  - At the clock edge: latch req_exp slice g into the hold register, latch g as owner, set last_grant=g, go to LAUNCH.
  - req_ready is 0 in every state other than IDLE.
  - req_valid must not depend on req_ready; a requester holds valid and data until it is accepted.
- LAUNCH: eng_data_valid=1 for exactly one cycle; wdog cleared; go to WAIT.
- WAIT:
  - eng_done=1 → rsp_max<=eng_max, rsp_err<=0, go to RESP.
  - Otherwise wdog++; when wdog reaches TIMEOUT-1 with no done, go to RECOVER.
  - If done and the timeout condition occur in the same cycle, done wins.
- RECOVER: eng_rstn=0 for one cycle; rsp_max<=0, rsp_err<=1; go to RESP.
- RESP:
  - rsp_valid=1; rsp_id, rsp_max and rsp_err remain stable until rsp_ready.
  - On rsp_valid&&rsp_ready: rsp_valid drops next cycle, go to IDLE.
  - A new grant is possible in the first IDLE cycle after the handshake.
- eng_exp is driven from the hold register and stays unchanged from LAUNCH through the end of RESP. This keeps the engine's combinational difference outputs valid for downstream logic while rsp_valid is high.
- eng_rstn = !RST && state!=RECOVER, generated from flops, glitch-free.
- eng_done seen in IDLE, LAUNCH or RESP is ignored (stale pulse).
- Latency, accept edge T to rsp_valid with a healthy engine: 9 cycles (LAUNCH T+1, done in T+8, rsp_valid T+9).
- Throughput: one job per 10 cycles when rsp_ready is tied high.
- Fairness: a continuously requesting requester waits at most NUM_REQ-1 jobs.
- Reset mid-job: all state is dropped, no response is produced, and the engine is reset through eng_rstn.

Decomposition:
- Package findmax_pkg:
  - state enum (IDLE, LAUNCH, WAIT, RESP, RECOVER), 3 bits
  - localparam ENG_LATENCY=7 (DataValid-cycle to done-cycle)
  - default N_EXP and EXP_W.
- Sub-module rr_arbiter (NUM_REQ): combinational round-robin pick from req_valid and last_grant, giving a one-hot grant plus an encoded ID.
- The FSM, hold register and watchdog stay in findmax_arbiter.

Test Plan:
- Single job: requester 2 valid, exp[k]=k%31, eng_done 7 cycles after eng_data_valid with eng_max=30 → req_ready=0100; rsp_valid in the 9th cycle after accept with rsp_id=2, rsp_max=30, rsp_err=0.
- Round-robin: all 4 valid continuously, rsp_ready=1 → grant order 0,1,2,3,0; each eng_exp matches the granted slice; jobs every 10 cycles.
- Backpressure: rsp_ready low 5 cycles → rsp_valid/rsp_max/rsp_id and eng_exp stable; no new req_ready until the cycle after the handshake.
- Watchdog: engine never asserts done, TIMEOUT=16 → eng_rstn low exactly 1 cycle, then rsp_valid with rsp_err=1, rsp_max=0; the next job completes normally.
- Edge cases: done and timeout in the same cycle → normal response; stale eng_done in IDLE → ignored, no response.
- Async reset: RST asserted during WAIT → rsp_valid=0 and eng_rstn=0 immediately; after release, state is IDLE and requester 0 has priority.
